// File: rtl/seven_seg_scan_capture.sv
// Captures a multiplexed active-low 8-digit seven-segment bus. Each digit is
// decoded back to a hex nibble, and the digits are reassembled into a 32-bit frame.
//
// state  | meaning
// WAIT   | idle, waiting for exactly one active anode
// COUNT  | counting consecutive identical synchronized samples
// DONE   | current pattern already accepted, waiting for any change
module seven_seg_scan_capture #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  segments_in,
  input  logic [7:0]  anodes_in,
  output logic [31:0] value,
  output logic        frame_valid,
  output logic [7:0]  digits_seen,
  output logic        digit_err,
  output logic        stale
);

  localparam logic [7:0]  STABLE_N  = 8'(STABLE_CYCLES);
  localparam logic [31:0] TIMEOUT_N = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_WAIT, S_COUNT, S_DONE} state_t;

  state_t      state, state_d;
  logic [6:0]  seg_m, seg_s, seg_p;
  logic [7:0]  an_m, an_s, an_p;
  logic [7:0]  cnt, cnt_d;
  logic [31:0] work, work_merged, tcnt, tcnt_d;
  logic [7:0]  seen_merged;
  logic [3:0]  nibble;
  logic [2:0]  digit_idx;
  logic        pair_changed, an_legal, decodable, accept, good_accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_m <= '1;
      seg_s <= '1;
      seg_p <= '1;
      an_m  <= '1;
      an_s  <= '1;
      an_p  <= '1;
    end else begin
      seg_m <= segments_in;
      seg_s <= seg_m;
      seg_p <= seg_s;
      an_m  <= anodes_in;
      an_s  <= an_m;
      an_p  <= an_s;
    end
  end

  assign pair_changed = {seg_s, an_s} != {seg_p, an_p};
  assign an_legal     = $onehot(~an_s);

  always_comb begin
    digit_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an_s[i]) digit_idx = 3'(i);
    end
  end

  always_comb begin
    decodable = 1'b1;
    nibble    = 4'h0;
    case (seg_s)
      7'b1000000: nibble = 4'h0;
      7'b1111001: nibble = 4'h1;
      7'b0100100: nibble = 4'h2;
      7'b0110000: nibble = 4'h3;
      7'b0011001: nibble = 4'h4;
      7'b0010010: nibble = 4'h5;
      7'b0000010: nibble = 4'h6;
      7'b1111000: nibble = 4'h7;
      7'b0000000: nibble = 4'h8;
      7'b0010000: nibble = 4'h9;
      7'b0001000: nibble = 4'hA;
      7'b0000011: nibble = 4'hB;
      7'b1000110: nibble = 4'hC;
      7'b0100001: nibble = 4'hD;
      7'b0000110: nibble = 4'hE;
      7'b0001110: nibble = 4'hF;
      default:    decodable = 1'b0;
    endcase
  end

  // Acceptance is decided on the edge where the count reaches the threshold,
  // so a threshold of 1 accepts straight out of WAIT.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    case (state)
      S_WAIT: begin
        if (an_legal) begin
          cnt_d   = 8'd1;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!pair_changed)  cnt_d = cnt + 8'd1;
        else if (an_legal)  cnt_d = 8'd1;
        else                state_d = S_WAIT;
      end
      S_DONE: begin
        if (pair_changed) state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
    if (state_d == S_COUNT && cnt_d == STABLE_N) begin
      accept  = 1'b1;
      state_d = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_WAIT;
      cnt   <= 8'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    work_merged = work;
    work_merged[{digit_idx, 2'b00} +: 4] = nibble;
    seen_merged = digits_seen | ~an_s;
  end

  assign good_accept = accept && decodable;
  assign tcnt_d      = good_accept ? 32'd0 : ((tcnt == '1) ? tcnt : tcnt + 32'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work        <= 32'd0;
      value       <= 32'd0;
      frame_valid <= 1'b0;
      digits_seen <= 8'd0;
      digit_err   <= 1'b0;
      tcnt        <= 32'd0;
      stale       <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      digit_err   <= 1'b0;
      tcnt        <= tcnt_d;
      // stale holds through the accept cycle and drops on the one after
      if (!good_accept) stale <= (tcnt_d >= TIMEOUT_N);
      if (accept) begin
        if (decodable) begin
          work <= work_merged;
          if (seen_merged == 8'hFF) begin
            value       <= work_merged;
            frame_valid <= 1'b1;
            digits_seen <= 8'd0;
          end else begin
            digits_seen <= seen_merged;
          end
        end else begin
          digit_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Self-checking bench for seven_seg_scan_capture. A reference model works on
// runs of identical pin samples and is compared against the DUT every cycle.
module tb_seven_seg_scan_capture;
  localparam int S = 4;
  localparam int T = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  segments_in;
  logic [7:0]  anodes_in;
  logic [31:0] value;
  logic        frame_valid;
  logic [7:0]  digits_seen;
  logic        digit_err;
  logic        stale;

  int total = 0;
  int bad   = 0;

  seven_seg_scan_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .segments_in(segments_in), .anodes_in(anodes_in),
    .value(value), .frame_valid(frame_valid), .digits_seen(digits_seen),
    .digit_err(digit_err), .stale(stale)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {bit v; bit ok; int idx; logic [3:0] nib;} ev_t;

  ev_t         dly [2];
  logic [3:0]  m_work [8];
  logic [31:0] m_value;
  logic [7:0]  m_seen;
  logic        m_fv, m_err, m_stale;
  int          m_age;
  logic [14:0] run_pair;
  int          run_len;
  bit          run_acc, prev_acc;
  logic [14:0] stim [$];

  function automatic int decode(logic [6:0] s);
    for (int k = 0; k < 16; k++) if (seg_tab[k] == s) return k;
    return -1;
  endfunction

  function automatic logic [42:0] dut_bus();
    return {value, frame_valid, digits_seen, digit_err, stale};
  endfunction

  function automatic logic [42:0] exp_bus();
    return {m_value, m_fv, m_seen, m_err, m_stale};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_work[k] = 4'h0;
    m_value = '0; m_seen = '0; m_fv = 0; m_err = 0; m_stale = 0; m_age = 0;
    run_pair = '1; run_len = 0; run_acc = 0; prev_acc = 0;
    dly[0] = '{v:0, ok:0, idx:0, nib:4'h0};
    dly[1] = dly[0];
  endtask

  // A run of identical legal samples is accepted at its S-th sample, or at its
  // (S+1)-th when it directly follows an accepted run (one sample is spent
  // leaving the accepted state). Outputs show the result two edges later.
  task automatic tick();
    ev_t ev, due;
    logic [14:0] p;
    int code;
    @(posedge clk);
    p = {segments_in, anodes_in};
    if (p == run_pair) run_len++;
    else begin
      prev_acc = run_acc; run_pair = p; run_len = 1; run_acc = 0;
    end
    ev = '{v:0, ok:0, idx:0, nib:4'h0};
    if ($countones(~anodes_in) == 1 && !run_acc && run_len == S + int'(prev_acc)) begin
      run_acc = 1;
      code = decode(segments_in);
      ev.v = 1; ev.ok = (code >= 0); ev.nib = 4'(code);
      for (int k = 0; k < 8; k++) if (!anodes_in[k]) ev.idx = k;
    end
    due = dly[1]; dly[1] = dly[0]; dly[0] = ev;
    m_fv = 0; m_err = 0;
    if (due.v && due.ok) begin
      m_work[due.idx] = due.nib;
      m_seen[due.idx] = 1'b1;
      m_age = 0;
      if (m_seen == 8'hFF) begin
        for (int k = 0; k < 8; k++) m_value[4*k +: 4] = m_work[k];
        m_fv = 1; m_seen = '0;
      end
    end else begin
      if (due.v) m_err = 1;
      if (m_age < 1000000) m_age++;
      m_stale = (m_age >= T);
    end
    #1;
  endtask

  task automatic push_digit(int i, logic [6:0] pat, int hold, int gap);
    for (int k = 0; k < hold; k++) stim.push_back({pat, 8'(~(8'h01 << i))});
    for (int k = 0; k < gap; k++)  stim.push_back({7'h7F, 8'hFF});
  endtask

  task automatic push_value(logic [31:0] v, int hold, int gap);
    for (int i = 0; i < 8; i++) push_digit(i, seg_tab[v[4*i +: 4]], hold, gap);
  endtask

  task automatic reset_dut();
    segments_in = '1; anodes_in = '1; reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    segments_in = '1; anodes_in = '1; reset = 1'b0;
    #2;
    total++;
    if (dut_bus() !== 43'd0) begin
      bad++; $display("FAIL reset_state got=%h exp=0", dut_bus());
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic test_scan_frame();
    int fv_cnt = 0;
    logic [7:0] prev_seen = 8'h00;
    logic [7:0] log_q [$];
    logic [7:0] exp_log [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'h00};
    push_digit(0, 7'h7F, 0, 2);
    push_value(32'h12345678, 10, 2);
    push_digit(0, 7'h7F, 0, 4);
    while (stim.size() > 0) begin
      {segments_in, anodes_in} = stim.pop_front();
      tick();
      total++;
      if (dut_bus() !== exp_bus()) begin
        bad++; $display("FAIL scan_frame got=%h exp=%h", dut_bus(), exp_bus());
      end
      if (frame_valid) fv_cnt++;
      if (digits_seen !== prev_seen) log_q.push_back(digits_seen);
      prev_seen = digits_seen;
    end
    total++;
    if (fv_cnt != 1) begin bad++; $display("FAIL scan_frame_pulses got=%0d exp=1", fv_cnt); end
    total++;
    if (value !== 32'h12345678) begin bad++; $display("FAIL scan_frame_value got=%h exp=12345678", value); end
    total++;
    if (log_q.size() != 8) begin
      bad++; $display("FAIL scan_frame_steps got=%0d exp=8", log_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        total++;
        if (log_q[k] !== exp_log[k]) begin
          bad++; $display("FAIL scan_frame_seen[%0d] got=%h exp=%h", k, log_q[k], exp_log[k]);
        end
      end
    end
  endtask

  task automatic test_stability();
    int k = 0;
    push_digit(3, seg_tab[9], 3, 6);
    while (stim.size() > 0) begin
      {segments_in, anodes_in} = stim.pop_front();
      tick();
      total++;
      if (dut_bus() !== exp_bus()) begin
        bad++; $display("FAIL short_hold got=%h exp=%h", dut_bus(), exp_bus());
      end
    end
    total++;
    if (digits_seen !== 8'h00) begin bad++; $display("FAIL short_hold_seen got=%h exp=00", digits_seen); end
    push_digit(3, seg_tab[9], 4, 4);
    while (stim.size() > 0) begin
      {segments_in, anodes_in} = stim.pop_front();
      tick();
      total++;
      if (digits_seen[3] !== (k >= 5)) begin
        bad++; $display("FAIL exact_hold_latency cyc=%0d got=%b exp=%b", k, digits_seen[3], k >= 5);
      end
      total++;
      if (dut_bus() !== exp_bus()) begin
        bad++; $display("FAIL exact_hold got=%h exp=%h", dut_bus(), exp_bus());
      end
      k++;
    end
  endtask

  task automatic test_blank_error();
    int err_cnt = 0, fv_cnt = 0;
    reset_dut();
    push_digit(0, 7'h7F, 8, 4);
    while (stim.size() > 0) begin
      {segments_in, anodes_in} = stim.pop_front();
      tick();
      total++;
      if (dut_bus() !== exp_bus()) begin
        bad++; $display("FAIL blank_err got=%h exp=%h", dut_bus(), exp_bus());
      end
      if (digit_err) err_cnt++;
      if (frame_valid) fv_cnt++;
    end
    total++;
    if (err_cnt != 1 || fv_cnt != 0 || digits_seen !== 8'h00) begin
      bad++; $display("FAIL blank_err_summary got err=%0d fv=%0d seen=%h exp err=1 fv=0 seen=00",
                      err_cnt, fv_cnt, digits_seen);
    end
  endtask

  task automatic test_illegal_anodes();
    int ev_cnt = 0;
    logic [6:0] s;
    s = seg_tab[$urandom_range(0, 15)];
    for (int k = 0; k < 20; k++) stim.push_back({s, 8'b11110011});
    push_digit(0, 7'h7F, 0, 4);
    while (stim.size() > 0) begin
      {segments_in, anodes_in} = stim.pop_front();
      tick();
      total++;
      if (dut_bus() !== exp_bus()) begin
        bad++; $display("FAIL illegal_anodes got=%h exp=%h", dut_bus(), exp_bus());
      end
      if (digit_err || frame_valid || digits_seen != 8'h00) ev_cnt++;
    end
    total++;
    if (ev_cnt != 0) begin bad++; $display("FAIL illegal_anodes_capture got=%0d exp=0", ev_cnt); end
  endtask

  task automatic test_stale();
    int k = 0, t_acc = -1, t_rise = -1, t_acc2 = -1, t_drop = -1;
    logic prev_stale = 1'b0;
    logic seen2_at_rise = 1'b0;
    reset_dut();
    push_digit(2, seg_tab[$urandom_range(0, 15)], 100, 10);
    push_digit(5, seg_tab[$urandom_range(0, 15)], 8, 4);
    while (stim.size() > 0) begin
      {segments_in, anodes_in} = stim.pop_front();
      tick();
      total++;
      if (dut_bus() !== exp_bus()) begin
        bad++; $display("FAIL stale_model got=%h exp=%h", dut_bus(), exp_bus());
      end
      if (t_acc < 0 && digits_seen[2]) t_acc = k;
      if (t_acc2 < 0 && digits_seen[5]) t_acc2 = k;
      if (stale && !prev_stale) begin t_rise = k; seen2_at_rise = digits_seen[2]; end
      if (!stale && prev_stale) t_drop = k;
      prev_stale = stale;
      k++;
    end
    total++;
    if (t_acc != 5) begin bad++; $display("FAIL stale_first_accept got=%0d exp=5", t_acc); end
    total++;
    if (t_rise != t_acc + 64) begin bad++; $display("FAIL stale_rise got=%0d exp=%0d", t_rise, t_acc + 64); end
    total++;
    if (seen2_at_rise !== 1'b1) begin bad++; $display("FAIL stale_keeps_seen got=%b exp=1", seen2_at_rise); end
    total++;
    if (t_acc2 < 0 || t_drop != t_acc2 + 1) begin
      bad++; $display("FAIL stale_drop got=%0d exp=%0d", t_drop, t_acc2 + 1);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] r;
    r = $urandom;
    push_value(r, 6, 1);
    push_digit(0, 7'h7F, 0, 4);
    for (int i = 0; i < 6; i++) push_digit(i, seg_tab[$urandom_range(0, 15)], 6, 1);
    while (stim.size() > 0) begin
      {segments_in, anodes_in} = stim.pop_front();
      tick();
      total++;
      if (dut_bus() !== exp_bus()) begin
        bad++; $display("FAIL pre_reset_scan got=%h exp=%h", dut_bus(), exp_bus());
      end
    end
    total++;
    if (value !== r || digits_seen !== 8'h3F) begin
      bad++; $display("FAIL pre_reset_state got value=%h seen=%h exp value=%h seen=3f", value, digits_seen, r);
    end
    segments_in = '1; anodes_in = '1; reset = 1'b0;
    #2;
    total++;
    if (dut_bus() !== 43'd0) begin bad++; $display("FAIL async_reset got=%h exp=0", dut_bus()); end
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    push_value(32'hDEADBEEF, 7, 2);
    push_digit(0, 7'h7F, 0, 4);
    while (stim.size() > 0) begin
      {segments_in, anodes_in} = stim.pop_front();
      tick();
      total++;
      if (dut_bus() !== exp_bus()) begin
        bad++; $display("FAIL post_reset_scan got=%h exp=%h", dut_bus(), exp_bus());
      end
    end
    total++;
    if (value !== 32'hDEADBEEF) begin bad++; $display("FAIL post_reset_value got=%h exp=deadbeef", value); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] s;
    logic [7:0] a;
    int r;
    reset_dut();
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      s = seg_tab[$urandom_range(0, 15)];
      a = 8'(~(8'h01 << $urandom_range(0, 7)));
      if (r == 0) begin
        a = 8'($urandom);
        if ($countones(~a) == 1) a = 8'h00;
      end else if (r == 1) begin
        s = 7'($urandom);
        for (int g = 0; g < 128 && decode(s) >= 0; g++) s = s + 7'd1;
      end
      for (int k = $urandom_range(1, 7); k > 0; k--) stim.push_back({s, a});
      for (int k = $urandom_range(0, 2); k > 0; k--) stim.push_back({7'h7F, 8'hFF});
    end
    push_digit(0, 7'h7F, 0, 4);
    while (stim.size() > 0) begin
      {segments_in, anodes_in} = stim.pop_front();
      tick();
      total++;
      if (dut_bus() !== exp_bus()) begin
        bad++; $display("FAIL back_to_back got=%h exp=%h", dut_bus(), exp_bus());
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_frame();
    test_stability();
    test_blank_error();
    test_illegal_anodes();
    test_stale();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
